// File: rtl/event_counter_pkg.sv
// Shared types for the event counter: count direction and range-limit behaviour.
package event_counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } count_dir_e;

    typedef enum logic {
        LIM_SAT  = 1'b0,
        LIM_WRAP = 1'b1
    } limit_mode_e;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for an already synchronised line.
// RESET_VAL=1 keeps a line that is high through reset release from producing an edge.
module edge_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_d;
    logic sig_q;

    // Next value of the delayed line is simply the current line.
    always_comb begin
        sig_d = sig_i;
    end

    // One-cycle delay of the input line.
    always_ff @(posedge clk) begin
        if (reset) begin
            sig_q <= RESET_VAL;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/event_counter.sv
// Up/down event counter with programmable modulus, wrap/saturate, parallel load,
// terminal-count pulse and sticky over/underflow flag.
module event_counter
    import event_counter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MODULUS   = 256,
    parameter bit EDGE_MODE = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             evt_i,
    input  logic             dir_i,
    input  logic             wrap_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o,
    output logic             ovf_o,
    output logic             zero_o
);

    if ((MODULUS < 2) || (64'(MODULUS) > (64'd1 << WIDTH))) begin : g_bad_modulus
        $error("event_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end

    localparam logic [WIDTH:0] MAX_C = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0] MOD_C = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0] ONE_C = (WIDTH+1)'(1);

    logic             rise_s;
    logic             qual_s;
    count_dir_e       dir_s;
    limit_mode_e      lim_s;
    logic [WIDTH:0]   count_ext_s;
    logic [WIDTH:0]   load_ext_s;
    logic [WIDTH:0]   inc_s;
    logic [WIDTH:0]   dec_s;

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;
    logic             tc_d;
    logic             tc_q;
    logic             ovf_d;
    logic             ovf_q;

    edge_detect #(
        .RESET_VAL (1'b1)
    ) u_edge_detect (
        .clk    (clk),
        .reset  (reset),
        .sig_i  (evt_i),
        .rise_o (rise_s)
    );

    assign qual_s      = EDGE_MODE ? rise_s : evt_i;
    assign dir_s       = count_dir_e'(dir_i);
    assign lim_s       = limit_mode_e'(wrap_i);
    assign count_ext_s = {1'b0, count_q};
    assign load_ext_s  = {1'b0, load_val_i};
    // A decrement from 0 borrows into the top bit, so both limits show up as "> MAX_C".
    assign inc_s       = count_ext_s + ONE_C;
    assign dec_s       = count_ext_s - ONE_C;

    // Next-count selection: clear > load > qualified event > hold.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q;
        if (clear_i) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (load_i) begin
            if (load_ext_s >= MOD_C) begin
                count_d = MAX_C[WIDTH-1:0];
            end else begin
                count_d = load_val_i;
            end
        end else if (qual_s) begin
            case (dir_s)
                DIR_UP: begin
                    if (inc_s > MAX_C) begin
                        tc_d    = 1'b1;
                        ovf_d   = 1'b1;
                        count_d = (lim_s == LIM_WRAP) ? '0 : count_q;
                    end else begin
                        count_d = inc_s[WIDTH-1:0];
                    end
                end
                DIR_DOWN: begin
                    if (dec_s > MAX_C) begin
                        tc_d    = 1'b1;
                        ovf_d   = 1'b1;
                        count_d = (lim_s == LIM_WRAP) ? MAX_C[WIDTH-1:0] : count_q;
                    end else begin
                        count_d = dec_s[WIDTH-1:0];
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end else begin
            count_d = count_q;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = tc_q;
    assign ovf_o   = ovf_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: tb/tb_event_counter.sv
// Scoreboard bench: an edge-mode and a level-mode counter (WIDTH=4, MODULUS=10) share
// stimulus; a reference model pushes expectations, a monitor pops and compares each cycle.
module tb_event_counter;

    localparam int W = 4;
    localparam int M = 10;

    logic         clk = 1'b0;
    logic         reset, evt_i, dir_i, wrap_i, load_i, clear_i;
    logic [W-1:0] load_val_i;
    logic [W-1:0] cnt_e, cnt_l;
    logic         tc_e, tc_l, ovf_e, ovf_l, zero_e, zero_l;

    always #5 clk = ~clk;

    event_counter #(.WIDTH(W), .MODULUS(M), .EDGE_MODE(1'b1)) dut_e (
        .clk(clk), .reset(reset), .evt_i(evt_i), .dir_i(dir_i), .wrap_i(wrap_i),
        .load_i(load_i), .load_val_i(load_val_i), .clear_i(clear_i),
        .count_o(cnt_e), .tc_o(tc_e), .ovf_o(ovf_e), .zero_o(zero_e));

    event_counter #(.WIDTH(W), .MODULUS(M), .EDGE_MODE(1'b0)) dut_l (
        .clk(clk), .reset(reset), .evt_i(evt_i), .dir_i(dir_i), .wrap_i(wrap_i),
        .load_i(load_i), .load_val_i(load_val_i), .clear_i(clear_i),
        .count_o(cnt_l), .tc_o(tc_l), .ovf_o(ovf_l), .zero_o(zero_l));

    typedef struct packed {
        logic [W-1:0] cnt;
        logic         tc;
        logic         ovf;
    } obs_t;

    typedef struct packed {
        obs_t e;
        obs_t l;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_exp;
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference model state, index 0 = edge mode, 1 = level mode.
    int   m_cnt[2];
    bit   m_tc[2];
    bit   m_ovf[2];
    bit   m_prev[2];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the counters present a fresh result after every clock edge.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_exp = sb_q.pop_front();
            check("edge_count", int'(cnt_e),  int'(mon_exp.e.cnt));
            check("edge_tc",    int'(tc_e),   int'(mon_exp.e.tc));
            check("edge_ovf",   int'(ovf_e),  int'(mon_exp.e.ovf));
            check("edge_zero",  int'(zero_e), int'(mon_exp.e.cnt == '0));
            check("lvl_count",  int'(cnt_l),  int'(mon_exp.l.cnt));
            check("lvl_tc",     int'(tc_l),   int'(mon_exp.l.tc));
            check("lvl_ovf",    int'(ovf_l),  int'(mon_exp.l.ovf));
            check("lvl_zero",   int'(zero_l), int'(mon_exp.l.cnt == '0));
        end
    end

    // Drive one cycle of inputs, predict the result, and advance the clock.
    task automatic step(input bit r, input bit e, input bit d, input bit w,
                        input bit ld, input int lv, input bit c);
        exp_t x;
        bit   q;
        reset = r; evt_i = e; dir_i = d; wrap_i = w;
        load_i = ld; load_val_i = W'(lv); clear_i = c;
        for (int k = 0; k < 2; k++) begin
            q = (k == 0) ? (e && !m_prev[k]) : e;
            if (r) begin
                m_cnt[k] = 0; m_tc[k] = 1'b0; m_ovf[k] = 1'b0; m_prev[k] = 1'b1;
            end else begin
                m_prev[k] = e;
                m_tc[k]   = 1'b0;
                if (c) begin
                    m_cnt[k] = 0; m_ovf[k] = 1'b0;
                end else if (ld) begin
                    m_cnt[k] = (lv >= M) ? M - 1 : lv;
                end else if (q) begin
                    if (d && m_cnt[k] == M - 1) begin
                        m_tc[k] = 1'b1; m_ovf[k] = 1'b1;
                        if (w) m_cnt[k] = 0;
                    end else if (!d && m_cnt[k] == 0) begin
                        m_tc[k] = 1'b1; m_ovf[k] = 1'b1;
                        if (w) m_cnt[k] = M - 1;
                    end else begin
                        m_cnt[k] = d ? m_cnt[k] + 1 : m_cnt[k] - 1;
                    end
                end
            end
        end
        x.e = '{cnt: W'(m_cnt[0]), tc: m_tc[0], ovf: m_ovf[0]};
        x.l = '{cnt: W'(m_cnt[1]), tc: m_tc[1], ovf: m_ovf[1]};
        sb_q.push_back(x);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse(input bit d, input bit w);
        step(1'b0, 1'b1, d, w, 1'b0, 0, 1'b0);
        step(1'b0, 1'b0, d, w, 1'b0, 0, 1'b0);
    endtask

    initial begin
        // Reset held high with the event line high, then released with it still high.
        repeat (3) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        repeat (2) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1);

        // Up with wrap: 1..9,0.
        repeat (10) pulse(1'b1, 1'b1);

        // Down with saturate from 2: 1,0,0,0.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0);
        repeat (4) pulse(1'b0, 1'b0);

        // Load clamp, load+clear priority, load coinciding with an edge.
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);

        // Level high for five cycles from zero.
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1);
        repeat (5) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);

        // Reset in the middle of counting.
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6, 1'b0);
        pulse(1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);

        // Randomised traffic with occasional reset/clear/load.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(63) == 0), $urandom_range(1), $urandom_range(1),
                 $urandom_range(1), ($urandom_range(15) == 0), int'($urandom_range(15)),
                 ($urandom_range(31) == 0));
        end

        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);
        #2;
        check("sb_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
